// File: rtl/id_exe_decode_stage.sv
// ID-stage instruction decoder plus the ID/EX pipeline register.
// The decoded instruction is registered for one cycle. Stall holds the
// register, flush loads a bubble, and a saturating counter tracks valid
// illegal opcodes.
module id_exe_decode_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       pc_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic [DATA_W-1:0] reg2_data,
    input  logic              stall,
    input  logic              flush,
    output logic [4:0]        src1_addr,
    output logic [4:0]        src2_addr,
    output logic [3:0]        EXE_CMD,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] st_val,
    output logic [4:0]        dest,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [1:0]        br_type,
    output logic [31:0]       pc_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_AND = 4'd4;
    localparam logic [3:0] CMD_OR  = 4'd5;
    localparam logic [3:0] CMD_NOR = 4'd6;
    localparam logic [3:0] CMD_XOR = 4'd7;
    localparam logic [3:0] CMD_SHL = 4'd8;
    localparam logic [3:0] CMD_SHA = 4'd9;
    localparam logic [3:0] CMD_SHR = 4'd10;

    logic [5:0]        w_opcode;
    logic [4:0]        w_dest;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_legal;
    logic              w_use_imm;
    logic [3:0]        w_cmd;
    logic              w_wb;
    logic              w_mr;
    logic              w_mw;
    logic [1:0]        w_br;
    logic              w_load;
    logic              w_cnt_inc;

    logic [3:0]        r_cmd;
    logic [DATA_W-1:0] r_val1;
    logic [DATA_W-1:0] r_val2;
    logic [DATA_W-1:0] r_st_val;
    logic [4:0]        r_dest;
    logic              r_wb;
    logic              r_mr;
    logic              r_mw;
    logic [1:0]        r_br;
    logic [31:0]       r_pc;
    logic              r_valid;
    logic [CNT_W-1:0]  r_illegal_cnt;

    assign w_opcode  = instr_in[31:26];
    assign w_dest    = instr_in[25:21];
    assign w_imm_ext = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

    // Register-file read addresses; store/branch read their second operand from the dest field
    assign src1_addr = instr_in[20:16];
    assign src2_addr = (w_opcode == OP_ST || w_opcode == OP_BNE || w_opcode == OP_BEZ)
                       ? instr_in[25:21] : instr_in[15:11];

    // Opcode decode into ALU command and control bits
    always_comb begin
        w_legal   = 1'b1;
        w_use_imm = 1'b0;
        w_cmd     = CMD_ADD;
        w_wb      = 1'b0;
        w_mr      = 1'b0;
        w_mw      = 1'b0;
        w_br      = 2'd0;
        case (w_opcode)
            OP_NOP:  ;
            OP_ADD:  begin w_cmd = CMD_ADD; w_wb = 1'b1; end
            OP_SUB:  begin w_cmd = CMD_SUB; w_wb = 1'b1; end
            OP_AND:  begin w_cmd = CMD_AND; w_wb = 1'b1; end
            OP_OR:   begin w_cmd = CMD_OR;  w_wb = 1'b1; end
            OP_NOR:  begin w_cmd = CMD_NOR; w_wb = 1'b1; end
            OP_XOR:  begin w_cmd = CMD_XOR; w_wb = 1'b1; end
            OP_SLA:  begin w_cmd = CMD_SHL; w_wb = 1'b1; end
            OP_SLL:  begin w_cmd = CMD_SHL; w_wb = 1'b1; end
            OP_SRA:  begin w_cmd = CMD_SHA; w_wb = 1'b1; end
            OP_SRL:  begin w_cmd = CMD_SHR; w_wb = 1'b1; end
            OP_ADDI: begin w_use_imm = 1'b1; w_wb = 1'b1; end
            OP_SUBI: begin w_use_imm = 1'b1; w_cmd = CMD_SUB; w_wb = 1'b1; end
            OP_LD:   begin w_use_imm = 1'b1; w_wb = 1'b1; w_mr = 1'b1; end
            OP_ST:   begin w_use_imm = 1'b1; w_mw = 1'b1; end
            OP_BEZ:  begin w_use_imm = 1'b1; w_br = 2'd1; end
            OP_BNE:  begin w_use_imm = 1'b1; w_br = 2'd2; end
            OP_JMP:  begin w_use_imm = 1'b1; w_br = 2'd3; end
            default: w_legal = 1'b0;
        endcase
    end

    // A real instruction is loaded only when valid and legal; everything else becomes a bubble
    assign w_load    = valid_in && w_legal;
    assign w_cnt_inc = valid_in && !w_legal && !stall && !flush && (r_illegal_cnt != '1);

    // ID/EX register: reset > flush > stall > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            r_cmd    <= '0;
            r_val1   <= '0;
            r_val2   <= '0;
            r_st_val <= '0;
            r_dest   <= '0;
            r_wb     <= 1'b0;
            r_mr     <= 1'b0;
            r_mw     <= 1'b0;
            r_br     <= 2'd0;
            r_pc     <= '0;
            r_valid  <= 1'b0;
        end else if (!stall) begin
            r_cmd    <= w_load ? w_cmd : '0;
            r_val1   <= w_load ? reg1_data : '0;
            r_val2   <= w_load ? (w_use_imm ? w_imm_ext : reg2_data) : '0;
            r_st_val <= w_load ? reg2_data : '0;
            r_dest   <= w_load ? w_dest : '0;
            r_wb     <= w_load && w_wb && (w_dest != 5'd0);
            r_mr     <= w_load && w_mr;
            r_mw     <= w_load && w_mw;
            r_br     <= w_load ? w_br : 2'd0;
            r_pc     <= w_load ? pc_in : '0;
            r_valid  <= w_load;
        end
    end

    // Saturating illegal-opcode counter, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign EXE_CMD     = r_cmd;
    assign val1        = r_val1;
    assign val2        = r_val2;
    assign st_val      = r_st_val;
    assign dest        = r_dest;
    assign WB_EN       = r_wb;
    assign MEM_R_EN    = r_mr;
    assign MEM_W_EN    = r_mw;
    assign br_type     = r_br;
    assign pc_out      = r_pc;
    assign valid_out   = r_valid;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_id_exe_decode_stage.sv
// Scoreboard bench for id_exe_decode_stage. The driver computes the expected
// ID/EX contents from an opcode table and pushes them; the monitor pops and
// compares one entry after every rising edge. The counter is built narrow so
// saturation is reachable in a few hundred cycles.
module tb_id_exe_decode_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       instr_in;
    logic [31:0]       pc_in;
    logic              valid_in;
    logic [DATA_W-1:0] reg1_data;
    logic [DATA_W-1:0] reg2_data;
    logic              stall;
    logic              flush;
    logic [4:0]        src1_addr;
    logic [4:0]        src2_addr;
    logic [3:0]        EXE_CMD;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] st_val;
    logic [4:0]        dest;
    logic              WB_EN;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [1:0]        br_type;
    logic [31:0]       pc_out;
    logic              valid_out;
    logic [CNT_W-1:0]  illegal_cnt;

    id_exe_decode_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_in(pc_in),
        .valid_in(valid_in), .reg1_data(reg1_data), .reg2_data(reg2_data),
        .stall(stall), .flush(flush), .src1_addr(src1_addr), .src2_addr(src2_addr),
        .EXE_CMD(EXE_CMD), .val1(val1), .val2(val2), .st_val(st_val), .dest(dest),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .br_type(br_type),
        .pc_out(pc_out), .valid_out(valid_out), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] st;
        logic [4:0]        dst;
        logic              wb;
        logic              mr;
        logic              mw;
        logic [1:0]        br;
        logic [31:0]       pc;
        logic              vld;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t q[$];
    exp_t model;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Opcode table: what each instruction means architecturally
    logic       t_legal [64];
    logic [3:0] t_cmd   [64];
    logic       t_imm   [64];
    logic       t_wb    [64];
    logic       t_mr    [64];
    logic       t_mw    [64];
    logic [1:0] t_br    [64];
    int         legal_ops[$];

    task automatic def(input int op, input int cmd, input bit imm, input bit wb,
                       input bit mr, input bit mw, input int br);
        t_legal[op] = 1'b1; t_cmd[op] = 4'(cmd); t_imm[op] = imm;
        t_wb[op] = wb; t_mr[op] = mr; t_mw[op] = mw; t_br[op] = 2'(br);
        legal_ops.push_back(op);
    endtask

    task automatic init_tables();
        for (int i = 0; i < 64; i++) begin
            t_legal[i] = 0; t_cmd[i] = 0; t_imm[i] = 0; t_wb[i] = 0;
            t_mr[i] = 0; t_mw[i] = 0; t_br[i] = 0;
        end
        def(0, 0, 0, 0, 0, 0, 0);
        def(1, 0, 0, 1, 0, 0, 0);   def(3, 2, 0, 1, 0, 0, 0);
        def(5, 4, 0, 1, 0, 0, 0);   def(6, 5, 0, 1, 0, 0, 0);
        def(7, 6, 0, 1, 0, 0, 0);   def(8, 7, 0, 1, 0, 0, 0);
        def(9, 8, 0, 1, 0, 0, 0);   def(10, 8, 0, 1, 0, 0, 0);
        def(11, 9, 0, 1, 0, 0, 0);  def(12, 10, 0, 1, 0, 0, 0);
        def(32, 0, 1, 1, 0, 0, 0);  def(33, 2, 1, 1, 0, 0, 0);
        def(36, 0, 1, 1, 1, 0, 0);  def(37, 0, 1, 0, 0, 1, 0);
        def(40, 0, 1, 0, 0, 0, 1);  def(41, 0, 1, 0, 0, 0, 2);
        def(42, 0, 1, 0, 0, 0, 3);
    endtask

    function automatic logic [31:0] mk(input int op, input int d, input int s1, input int low16);
        logic [31:0] r;
        r = {6'(op), 5'(d), 5'(s1), 16'(low16)};
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One cycle of stimulus: drive after the falling edge, advance the model, queue expectation
    task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                        input logic v, input logic [31:0] r1, input logic [31:0] r2,
                        input logic st, input logic fl);
        int op;
        logic [4:0] exp_src2;
        @(negedge clk);
        rst_n = rst; instr_in = ins; pc_in = pc; valid_in = v;
        reg1_data = r1; reg2_data = r2; stall = st; flush = fl;
        op = int'(ins[31:26]);
        if (!rst) begin
            model = '0;
        end else if (fl) begin
            model = '{cmd: 0, v1: 0, v2: 0, st: 0, dst: 0, wb: 0, mr: 0, mw: 0,
                      br: 0, pc: 0, vld: 0, cnt: model.cnt};
        end else if (!st) begin
            if (v && !t_legal[op] && int'(model.cnt) < CNT_MAX) model.cnt = model.cnt + 1'b1;
            if (v && t_legal[op]) begin
                model.cmd = t_cmd[op];
                model.v1  = r1;
                model.v2  = t_imm[op] ? 32'($signed(ins[15:0])) : r2;
                model.st  = r2;
                model.dst = ins[25:21];
                model.wb  = t_wb[op] && (ins[25:21] != 0);
                model.mr  = t_mr[op];
                model.mw  = t_mw[op];
                model.br  = t_br[op];
                model.pc  = pc;
                model.vld = 1'b1;
            end else begin
                model = '{cmd: 0, v1: 0, v2: 0, st: 0, dst: 0, wb: 0, mr: 0, mw: 0,
                          br: 0, pc: 0, vld: 0, cnt: model.cnt};
            end
        end
        q.push_back(model);
        #1;
        exp_src2 = (op == 37 || op == 40 || op == 41) ? ins[25:21] : ins[15:11];
        check("src1_addr", 256'(src1_addr), 256'(ins[20:16]));
        check("src2_addr", 256'(src2_addr), 256'(exp_src2));
    endtask

    function automatic exp_t actual();
        exp_t a;
        a = '{cmd: EXE_CMD, v1: val1, v2: val2, st: st_val, dst: dest, wb: WB_EN,
              mr: MEM_R_EN, mw: MEM_W_EN, br: br_type, pc: pc_out, vld: valid_out,
              cnt: illegal_cnt};
        return a;
    endfunction

    // Monitor: one expectation per rising edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("idex_regs", 256'(actual()), 256'(e));
            end
        end
    end

    initial begin
        int op;
        init_tables();
        model = '0;
        rst_n = 1'b0; instr_in = $urandom; pc_in = $urandom; valid_in = 1'b1;
        reg1_data = $urandom; reg2_data = $urandom; stall = 1'b0; flush = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++)
            step(0, $urandom, $urandom, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));

        step(1, mk(1, 3, 1, 16'h1000), 32'h100, 1, 5, 7, 0, 0);            // ADD
        step(1, mk(33, 4, 2, 16'hFFFE), 32'h104, 1, 10, 3, 0, 0);          // SUBI negative imm
        step(1, mk(37, 6, 2, 16'h0004), 32'h108, 1, 8, 9, 0, 0);           // ST
        step(1, mk(1, 0, 2, 16'h1800), 32'h10C, 1, 1, 2, 0, 0);            // ADD to r0

        // Stall for three cycles while the instruction changes
        step(1, mk(36, 7, 1, 16'h0010), 32'h110, 1, 100, 200, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, $urandom, $urandom, 1, $urandom, $urandom, 1, 0);
        step(1, mk(3, 9, 1, 16'h1000), 32'h120, 1, 3, 4, 1, 1);            // stall+flush

        // Every table opcode, then illegal opcode handling
        foreach (legal_ops[i])
            step(1, mk(legal_ops[i], 1 + i, 2, 16'h8000 | (i << 11)), 32'h200 + i * 4, 1,
                 $urandom, $urandom, 0, 0);
        step(1, mk(63, 5, 1, 16'h0800), 32'h300, 1, 1, 1, 0, 0);
        step(1, mk(63, 5, 1, 16'h0800), 32'h304, 1, 1, 1, 1, 0);           // stalled: no count
        step(1, mk(63, 5, 1, 16'h0800), 32'h308, 1, 1, 1, 0, 1);           // flushed: no count
        step(1, mk(63, 5, 1, 16'h0800), 32'h30C, 0, 1, 1, 0, 0);           // invalid: no count

        // Asynchronous reset during a stalled LD
        step(1, mk(36, 8, 1, 16'h0020), 32'h400, 1, 50, 60, 0, 0);
        step(1, mk(1, 9, 1, 16'h0800), 32'h404, 1, 70, 80, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 256'(actual()), 256'(0));
        model = '0;
        q[q.size() - 1] = '0;
        step(1, mk(5, 10, 3, 16'h2000), 32'h500, 1, 32'hF0F0, 32'h0FF0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, legal_ops.size() - 1)]
                                             : int'($urandom_range(0, 63));
            step(1, {6'(op), 26'($urandom)}, $urandom, ($urandom_range(0, 99) < 85),
                 $urandom, $urandom, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
        end

        // Drive the counter into saturation
        for (int i = 0; i < CNT_MAX + 3; i++)
            step(1, mk(63, 1, 1, i), 32'h600, 1, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 256'(q.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_exe_decode_stage.md
Name: id_exe_decode_stage

Overview:
- Decode half of the ID stage plus the ID/EX pipeline register of the pipelined MIPS core.
- Decodes the fetched instruction into the 4-bit EXE_CMD and operand pair consumed by the execute-stage ALU, together with memory and writeback control.
- Registers all results for one cycle, and supports stall (hold), flush (bubble insertion) and a saturating illegal-opcode counter.

Parameters:
- DATA_W, 32, datapath and operand width.
- CNT_W, 16, width of the illegal-opcode counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_in  in  32  instruction from IF/ID; opcode[31:26], dest[25:21], src1[20:16], src2[15:11], imm[15:0].
- pc_in  in  32  PC of instr_in.
- valid_in  in  1  instr_in is a real instruction.
- reg1_data  in  32  register-file read of src1.
- reg2_data  in  32  register-file read of src2.
- stall  in  1  hold the ID/EX register.
- flush  in  1  replace the next ID/EX contents with a bubble.
- src1_addr  out  5  combinational instr_in[20:16], drives the register file.
- src2_addr  out  5  combinational: instr_in[15:11] for R-type; instr_in[25:21] for ST/BNE/BEZ.
- EXE_CMD  out  4  registered ALU command.
- val1  out  32  registered ALU operand 1.
- val2  out  32  registered ALU operand 2 (register or sign-extended immediate).
- st_val  out  32  registered store data (reg2_data).
- dest  out  5  registered writeback register.
- WB_EN  out  1  registered register writeback enable.
- MEM_R_EN  out  1  registered load enable.
- MEM_W_EN  out  1  registered store enable.
- br_type  out  2  registered branch type: 0 none, 1 BEZ, 2 BNE, 3 JMP.
- pc_out  out  32  registered PC.
- valid_out  out  1  registered valid.
- illegal_cnt  out  CNT_W  count of valid illegal opcodes; saturates at all-ones.

Behaviour:
- EXE_CMD encoding (fixed): ADD 0, SUB 2, AND 4, OR 5, NOR 6, XOR 7, SHL 8, SHA 9 (arithmetic right), SHR 10 (logical right).
- Opcode decode, listed as opcode -> EXE_CMD, val2 source, WB / MR / MW:
  - 0 NOP -> ADD, reg, 0/0/0.
  - 1 ADD -> 0; 3 SUB -> 2; 5 AND -> 4; 6 OR -> 5; 7 NOR -> 6; 8 XOR -> 7; 9 SLA -> 8; 10 SLL -> 8; 11 SRA -> 9; 12 SRL -> 10. All use val2 = reg2_data, WB=1.
  - 32 ADDI -> ADD, imm, WB=1.
  - 33 SUBI -> SUB, imm, WB=1.
  - 36 LD -> ADD, imm, WB=1, MR=1.
  - 37 ST -> ADD, imm, MW=1.
  - 40 BEZ -> ADD, imm, br=1.
  - 41 BNE -> ADD, imm, br=2.
  - 42 JMP -> ADD, imm, br=3.
  - Any other opcode is illegal: decodes as a bubble.
- Immediate: sign-extended from imm[15:0] to DATA_W bits.
- Writeback to dest 0: WB_EN is forced to 0 whenever dest==0.
- Operands: val1 = reg1_data for every opcode.
- Register update, priority order:
  1. Reset (rst_n low, asynchronous): all registered outputs and illegal_cnt go to 0. This equals a bubble with EXE_CMD=0 and valid_out=0. Effect is immediate, even mid-stall.
  2. flush=1: load a bubble (all enables 0, br_type 0, valid_out 0, EXE_CMD 0, data fields 0). Flush overrides stall.
  3. stall=1: hold every register unchanged.
  4. Otherwise: load the decoded instr_in with valid_out=valid_in.
- valid_in=0 loads a bubble.
- Latency: instr_in to outputs is exactly one clk edge.
- illegal_cnt: increments by 1 on an edge where valid_in=1, the opcode is illegal, stall=0 and flush=0. It never wraps. It is not cleared by flush.
- No other state is kept. src1_addr and src2_addr are purely combinational.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release rst_n, then present ADD (opcode 1, dest 3, reg1=5, reg2=7) -> next edge: EXE_CMD=0, val1=5, val2=7, dest=3, WB_EN=1, valid_out=1.
- Immediate: SUBI with imm=16'hFFFE, reg1=10 -> EXE_CMD=2, val2=32'hFFFFFFFE, WB_EN=1. Then ST with imm=4, reg2=9 -> MEM_W_EN=1, WB_EN=0, st_val=9, val2=4.
- Stall/flush: assert stall 3 cycles while instr_in changes -> outputs frozen. Assert stall and flush together -> bubble (valid_out=0, all enables 0).
- Every opcode in the table -> matching EXE_CMD value. SRA gives 9, SRL gives 10, SLA and SLL both give 8. ADD with dest=0 -> WB_EN=0.
- Illegal opcode 63 with valid_in=1 -> bubble, illegal_cnt increments. Same opcode with stall=1 -> no increment. Preload near saturation (force 65534, then 3 illegals) -> illegal_cnt stays 65535.
- Pull rst_n low asynchronously mid-cycle during a stalled LD -> outputs clear before the next edge. After release, first edge loads the current instr_in.
